// File: rtl/mvm_pkg.sv
// mvm_pkg: FSM state encoding and default widths shared by the mvm_driver slice.
package mvm_pkg;
    localparam int OWIDTH_D        = 32;
    localparam int MEM_DATAW_D     = 64;
    localparam int VEC_MEM_DEPTH_D = 256;
    localparam int MAT_MEM_DEPTH_D = 512;
    localparam int NUM_OLANES_D    = 8;

    typedef enum logic [2:0] {IDLE, LOAD_VEC, LOAD_MAT, KICK, RUN, DONE} state_t;
endpackage

// File: rtl/mvm_res_buf.sv
// mvm_res_buf: captures one MVM result row (all lanes) and serializes it lane 0..N-1.
// With MVM_DRIVER_OVF_EN a row arriving while busy is dropped; otherwise it overwrites.
module mvm_res_buf
    import mvm_pkg::*;
#(
    parameter int  OWIDTH     = OWIDTH_D,
    parameter int  NUM_OLANES = NUM_OLANES_D,
    localparam int LW         = (NUM_OLANES > 1) ? $clog2(NUM_OLANES) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cap,
    input  logic [OWIDTH*NUM_OLANES-1:0] row,
    input  logic                         r_ready,
    output logic [OWIDTH-1:0]            r_data,
    output logic [LW-1:0]                r_lane,
    output logic                         r_valid,
    output logic                         ovf
);
    logic [NUM_OLANES-1:0][OWIDTH-1:0] row_q;
    logic [LW-1:0]                     lane_q;
    logic                              valid_q;
    logic                              hs, last, load;

    assign hs   = valid_q & r_ready;
    assign last = lane_q == LW'(NUM_OLANES - 1);
`ifdef MVM_DRIVER_OVF_EN
    // A capture landing on the final-lane handshake finds the buffer free.
    assign load = cap & (~valid_q | (hs & last));
    assign ovf  = cap & ~load;
`else
    assign load = cap;
    assign ovf  = 1'b0;
`endif
    assign r_data  = row_q[lane_q];
    assign r_lane  = lane_q;
    assign r_valid = valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q   <= '0;
            lane_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            row_q   <= row;
            lane_q  <= '0;
            valid_q <= 1'b1;
        end else if (hs) begin
            lane_q  <= last ? '0 : lane_q + 1'b1;
            valid_q <= ~last;
        end
    end
endmodule

// File: rtl/mvm_driver.sv
// mvm_driver: loads vector/matrix memories from a stream, kicks the MVM and streams its results.
// Optional MVM_DRIVER_OVF_EN: drop rows that arrive while the result buffer is busy and flag it.
module mvm_driver
    import mvm_pkg::*;
#(
    parameter int  OWIDTH        = OWIDTH_D,
    parameter int  MEM_DATAW     = MEM_DATAW_D,
    parameter int  VEC_MEM_DEPTH = VEC_MEM_DEPTH_D,
    parameter int  MAT_MEM_DEPTH = MAT_MEM_DEPTH_D,
    parameter int  NUM_OLANES    = NUM_OLANES_D,
    localparam int VEC_ADDRW     = $clog2(VEC_MEM_DEPTH),
    localparam int MAT_ADDRW     = $clog2(MAT_MEM_DEPTH),
    localparam int LW            = (NUM_OLANES > 1) ? $clog2(NUM_OLANES) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_go,
    input  logic [VEC_ADDRW:0]           i_num_words,
    input  logic [MAT_ADDRW:0]           i_num_rows,
    input  logic [MEM_DATAW-1:0]         s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [OWIDTH-1:0]            r_data,
    output logic [LW-1:0]                r_lane,
    output logic                         r_valid,
    input  logic                         r_ready,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_overflow,
    output logic [MEM_DATAW-1:0]         o_wdata,
    output logic [VEC_ADDRW-1:0]         o_vec_waddr,
    output logic                         o_vec_wen,
    output logic [MAT_ADDRW-1:0]         o_mat_waddr,
    output logic [NUM_OLANES-1:0]        o_mat_wen,
    output logic                         o_start,
    output logic [VEC_ADDRW:0]           o_vec_num_words,
    output logic [MAT_ADDRW:0]           o_mat_num_rows_per_olane,
    input  logic                         i_mvm_busy,
    input  logic [OWIDTH*NUM_OLANES-1:0] i_mvm_result,
    input  logic                         i_mvm_valid
);
    localparam int PW = VEC_ADDRW + MAT_ADDRW + 2;

    state_t               state;
    logic [VEC_ADDRW:0]   vec_cnt;
    logic [PW-1:0]        mat_cnt, rw_q;
    logic [LW-1:0]        lane;
    logic [MAT_ADDRW:0]   cap_cnt;
    logic                 beat, go_ok, cap, mat_wrap, ovf;

    assign s_ready  = (state == LOAD_VEC) | (state == LOAD_MAT);
    assign o_busy   = state != IDLE;
    assign beat     = s_valid & s_ready;
    assign go_ok    = (state == IDLE) & i_go & (|i_num_words) & (|i_num_rows);
    assign cap      = (state == RUN) & i_mvm_valid;
    assign mat_wrap = mat_cnt + 1'b1 == rw_q;

    mvm_res_buf #(.OWIDTH(OWIDTH), .NUM_OLANES(NUM_OLANES)) u_buf (
        .clk(clk), .rst(rst), .cap(cap), .row(i_mvm_result), .r_ready(r_ready),
        .r_data(r_data), .r_lane(r_lane), .r_valid(r_valid), .ovf(ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                    <= IDLE;
            vec_cnt                  <= '0;
            mat_cnt                  <= '0;
            rw_q                     <= '0;
            lane                     <= '0;
            cap_cnt                  <= '0;
            o_done                   <= 1'b0;
            o_wdata                  <= '0;
            o_vec_waddr              <= '0;
            o_vec_wen                <= 1'b0;
            o_mat_waddr              <= '0;
            o_mat_wen                <= '0;
            o_start                  <= 1'b0;
            o_vec_num_words          <= '0;
            o_mat_num_rows_per_olane <= '0;
        end else begin
            o_vec_wen <= 1'b0;
            o_mat_wen <= '0;
            o_start   <= 1'b0;
            o_done    <= 1'b0;
            case (state)
                IDLE: if (go_ok) begin
                    o_vec_num_words          <= i_num_words;
                    o_mat_num_rows_per_olane <= i_num_rows;
                    rw_q                     <= PW'(i_num_words) * PW'(i_num_rows);
                    vec_cnt                  <= '0;
                    mat_cnt                  <= '0;
                    lane                     <= '0;
                    cap_cnt                  <= '0;
                    state                    <= LOAD_VEC;
                end
                LOAD_VEC: if (beat) begin
                    o_wdata     <= s_data;
                    o_vec_waddr <= vec_cnt[VEC_ADDRW-1:0];
                    o_vec_wen   <= 1'b1;
                    vec_cnt     <= vec_cnt + 1'b1;
                    if (vec_cnt + 1'b1 == o_vec_num_words) state <= LOAD_MAT;
                end
                LOAD_MAT: if (beat) begin
                    o_wdata     <= s_data;
                    o_mat_waddr <= mat_cnt[MAT_ADDRW-1:0];
                    o_mat_wen   <= NUM_OLANES'(1) << lane;
                    mat_cnt     <= mat_wrap ? '0 : mat_cnt + 1'b1;
                    if (mat_wrap) lane <= lane + 1'b1;
                    // o_start is registered so it is high exactly during KICK.
                    if (mat_wrap && lane == LW'(NUM_OLANES - 1)) begin
                        state   <= KICK;
                        o_start <= 1'b1;
                    end
                end
                KICK: state <= RUN;
                RUN: begin
                    if (cap) cap_cnt <= cap_cnt + 1'b1;
                    if (cap_cnt == o_mat_num_rows_per_olane && !r_valid && !i_mvm_busy && !cap) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MVM_DRIVER_OVF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) o_overflow <= 1'b0;
        else if (go_ok) o_overflow <= 1'b0;
        else if (ovf) o_overflow <= 1'b1;
    end
`else
    assign o_overflow = ovf;
`endif
endmodule

// File: tb/tb_mvm_driver.sv
// tb_mvm_driver: randomized jobs against a memory/result log model of the driver's contract.
module tb_mvm_driver;
    localparam int OW = 32, DW = 64, VA = 8, MA = 9, NL = 8;

    logic              clk = 0, rst = 0, i_go = 0, s_valid = 0, r_ready = 1;
    logic              i_mvm_busy = 0, i_mvm_valid = 0;
    logic [VA:0]       i_num_words = 0;
    logic [MA:0]       i_num_rows = 0;
    logic [DW-1:0]     s_data = 0;
    logic [NL*OW-1:0]  i_mvm_result = 0;
    logic              s_ready, r_valid, o_busy, o_done, o_overflow, o_vec_wen, o_start;
    logic [OW-1:0]     r_data;
    logic [2:0]        r_lane;
    logic [DW-1:0]     o_wdata;
    logic [VA-1:0]     o_vec_waddr;
    logic [MA-1:0]     o_mat_waddr;
    logic [NL-1:0]     o_mat_wen;
    logic [VA:0]       o_vec_num_words;
    logic [MA:0]       o_mat_num_rows_per_olane;

    mvm_driver dut (
        .clk(clk), .rst(rst), .i_go(i_go), .i_num_words(i_num_words), .i_num_rows(i_num_rows),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .r_data(r_data), .r_lane(r_lane), .r_valid(r_valid), .r_ready(r_ready),
        .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow),
        .o_wdata(o_wdata), .o_vec_waddr(o_vec_waddr), .o_vec_wen(o_vec_wen),
        .o_mat_waddr(o_mat_waddr), .o_mat_wen(o_mat_wen), .o_start(o_start),
        .o_vec_num_words(o_vec_num_words), .o_mat_num_rows_per_olane(o_mat_num_rows_per_olane),
        .i_mvm_busy(i_mvm_busy), .i_mvm_result(i_mvm_result), .i_mvm_valid(i_mvm_valid)
    );

    always #5 clk = ~clk;

    typedef struct {int unsigned addr; logic [DW-1:0] data;} vw_t;
    typedef struct {logic [NL-1:0] wen; int unsigned addr; logic [DW-1:0] data;} mw_t;
    typedef struct {int unsigned lane; logic [OW-1:0] data;} rs_t;

    int            checks = 0, errors = 0, starts = 0, dones = 0;
    logic [DW-1:0] sent_q[$];
    logic [NL*OW-1:0] rows_q[$];
    vw_t           vec_log[$];
    mw_t           mat_log[$];
    rs_t           res_log[$];

    // Outputs are registered, so a negedge sample is one full cycle of activity.
    always @(negedge clk) begin
        if (o_vec_wen) vec_log.push_back('{o_vec_waddr, o_wdata});
        if (|o_mat_wen) mat_log.push_back('{o_mat_wen, o_mat_waddr, o_wdata});
        if (o_start) starts++;
        if (o_done) dones++;
        if (r_valid && r_ready) res_log.push_back('{r_lane, r_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        sent_q.delete(); rows_q.delete(); vec_log.delete(); mat_log.delete(); res_log.delete();
        starts = 0; dones = 0;
    endtask

    task automatic start_job(input int w, input int r);
        i_num_words = VA'(w); i_num_rows = MA'(r); i_go = 1;
        cycle();
        i_go = 0;
    endtask

    task automatic send_beats(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] d;
            bit ok;
            d = {$urandom, $urandom};
            if (gaps) repeat ($urandom_range(0, 2)) cycle();
            s_valid = 1; s_data = d; sent_q.push_back(d); ok = 0;
            for (int t = 0; t < 1000; t++) begin
                @(negedge clk);
                if (s_ready) begin ok = 1; break; end
            end
            @(posedge clk); #1;
            s_valid = 0;
            if (!ok) begin
                checks++; errors++;
                $display("FAIL s_ready timeout beat %0d got 0 want 1", i);
                return;
            end
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 0;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            if (o_start) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL o_start timeout got 0 want 1");
        end
    endtask

    task automatic wait_cond_lane(input int mode);
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (mode == 1 ? (r_valid && r_lane == 3'(NL - 2)) : !r_valid) break;
        end
        @(posedge clk); #1;
    endtask

    // mode 0: next row after buffer drains; mode 1: next row lands on final-lane handshake
    task automatic mvm_respond(input int rows, input int maxgap, input int mode);
        bit ok;
        wait_start(ok);
        if (!ok) return;
        @(posedge clk); #1;
        i_mvm_busy = 1;
        for (int r = 0; r < rows; r++) begin
            logic [NL*OW-1:0] row;
            if (r > 0) wait_cond_lane(mode);
            else repeat ($urandom_range(0, maxgap)) cycle();
            for (int l = 0; l < NL; l++) row[l*OW +: OW] = $urandom;
            rows_q.push_back(row);
            i_mvm_valid = 1; i_mvm_result = row;
            cycle();
            i_mvm_valid = 0;
        end
        i_mvm_busy = 0;
    endtask

    task automatic wait_done(input int budget);
        for (int t = 0; t < budget && dones == 0; t++) @(negedge clk);
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL done_count got %0d want 1", dones); end
        cycle();
    endtask

    task automatic check_loads(input int w, input int r);
        int rw;
        rw = r * w;
        checks++;
        if (vec_log.size() !== w || mat_log.size() !== NL * rw) begin
            errors++;
            $display("FAIL load_count got vec=%0d mat=%0d want vec=%0d mat=%0d",
                     vec_log.size(), mat_log.size(), w, NL * rw);
            return;
        end
        for (int k = 0; k < w; k++) begin
            checks++;
            if (vec_log[k].addr !== k || vec_log[k].data !== sent_q[k]) begin
                errors++;
                $display("FAIL vec_write %0d got addr=%0d data=%h want addr=%0d data=%h",
                         k, vec_log[k].addr, vec_log[k].data, k, sent_q[k]);
            end
        end
        for (int i = 0; i < NL * rw; i++) begin
            logic [NL-1:0] ew;
            ew = NL'(1) << (i / rw);
            checks++;
            if (mat_log[i].wen !== ew || mat_log[i].addr !== i % rw || mat_log[i].data !== sent_q[w + i]) begin
                errors++;
                $display("FAIL mat_write %0d got wen=%b addr=%0d data=%h want wen=%b addr=%0d data=%h",
                         i, mat_log[i].wen, mat_log[i].addr, mat_log[i].data, ew, i % rw, sent_q[w + i]);
            end
        end
    endtask

    task automatic check_results(input rs_t exp[$]);
        checks++;
        if (res_log.size() !== exp.size()) begin
            errors++;
            $display("FAIL result_count got %0d want %0d", res_log.size(), exp.size());
            return;
        end
        foreach (exp[i]) begin
            checks++;
            if (res_log[i].lane !== exp[i].lane || res_log[i].data !== exp[i].data) begin
                errors++;
                $display("FAIL result %0d got lane=%0d data=%h want lane=%0d data=%h",
                         i, res_log[i].lane, res_log[i].data, exp[i].lane, exp[i].data);
            end
        end
    endtask

    task automatic rows_expected(output rs_t exp[$]);
        exp.delete();
        foreach (rows_q[r]) for (int l = 0; l < NL; l++) exp.push_back('{l, rows_q[r][l*OW +: OW]});
    endtask

    task automatic run_job(input int w, input int r, input bit gaps, input int maxgap,
                           input bit rand_ready, input int mode);
        rs_t exp[$];
        clear_logs();
        r_ready = 1;
        start_job(w, r);
        fork
            send_beats(w + NL * r * w, gaps);
            mvm_respond(r, maxgap, mode);
            if (rand_ready) begin
                for (int t = 0; t < 5000 && dones == 0; t++) begin
                    r_ready = 1'($urandom_range(0, 1));
                    cycle();
                end
                r_ready = 1;
            end
        join
        wait_done(3000);
        check_loads(w, r);
        rows_expected(exp);
        check_results(exp);
        checks++;
        if (starts !== 1) begin errors++; $display("FAIL start_count got %0d want 1", starts); end
    endtask

    task automatic test_reset();
        repeat (3) cycle();
        @(negedge clk);
        checks++;
        if ({o_busy, s_ready, r_valid, o_done, o_overflow, o_vec_wen, o_start} !== 7'b0 ||
            o_mat_wen !== 0 || r_data !== 0 || o_vec_num_words !== 0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b rdy=%b rv=%b done=%b ovf=%b vwen=%b mwen=%b start=%b want 0",
                     o_busy, s_ready, r_valid, o_done, o_overflow, o_vec_wen, o_mat_wen, o_start);
        end
        @(posedge clk); #1;
        rst = 1;
        cycle();
    endtask

    task automatic test_basic();
        run_job(2, 1, 0, 0, 0, 0);
    endtask

    task automatic test_gaps();
        run_job(3, 2, 1, 4, 1, 0);
    endtask

    task automatic test_back_to_back();
        run_job(1, 3, 0, 0, 0, 1);
        checks++;
        if (o_overflow !== 0) begin errors++; $display("FAIL b2b_overflow got %b want 0", o_overflow); end
    endtask

    task automatic test_stall();
        logic [NL*OW-1:0] a, b;
        logic [OW-1:0]    d0;
        logic [2:0]       l0;
        bit               ok, stable;
        rs_t              exp[$];
        clear_logs();
        r_ready = 1;
        start_job(1, 2);
        send_beats(1 + NL * 2, 0);
        wait_start(ok);
        if (!ok) return;
        @(posedge clk); #1;
        i_mvm_busy = 1;
        for (int l = 0; l < NL; l++) begin a[l*OW +: OW] = $urandom; b[l*OW +: OW] = $urandom; end
        i_mvm_valid = 1; i_mvm_result = a;
        cycle();
        i_mvm_valid = 0;
        cycle(); cycle();
        r_ready = 0;
        @(negedge clk);
        d0 = r_data; l0 = r_lane; stable = 1;
        repeat (20) begin
            @(negedge clk);
            if (r_data !== d0 || r_lane !== l0 || !r_valid) stable = 0;
        end
        @(posedge clk); #1;
        checks++;
        if (!stable || l0 !== 3'd2 || d0 !== a[2*OW +: OW]) begin
            errors++;
            $display("FAIL stall_hold got stable=%b lane=%0d data=%h want stable=1 lane=2 data=%h",
                     stable, l0, d0, a[2*OW +: OW]);
        end
        i_mvm_valid = 1; i_mvm_result = b;
        cycle();
        i_mvm_valid = 0; i_mvm_busy = 0;
        @(negedge clk);
        for (int l = 0; l < 2; l++) exp.push_back('{l, a[l*OW +: OW]});
`ifdef MVM_DRIVER_OVF_EN
        checks++;
        if (o_overflow !== 1 || r_lane !== 3'd2 || r_data !== a[2*OW +: OW]) begin
            errors++;
            $display("FAIL stall_second_row got ovf=%b lane=%0d data=%h want ovf=1 lane=2 data=%h",
                     o_overflow, r_lane, r_data, a[2*OW +: OW]);
        end
        for (int l = 2; l < NL; l++) exp.push_back('{l, a[l*OW +: OW]});
`else
        checks++;
        if (o_overflow !== 0 || r_lane !== 3'd0 || r_data !== b[OW-1:0]) begin
            errors++;
            $display("FAIL stall_second_row got ovf=%b lane=%0d data=%h want ovf=0 lane=0 data=%h",
                     o_overflow, r_lane, r_data, b[OW-1:0]);
        end
        for (int l = 0; l < NL; l++) exp.push_back('{l, b[l*OW +: OW]});
`endif
        @(posedge clk); #1;
        r_ready = 1;
        wait_done(500);
        check_results(exp);
    endtask

    task automatic test_ignore();
        rs_t exp[$];
        bit  ok;
        clear_logs();
        start_job(0, 1);
        start_job(1, 0);
        cycle();
        @(negedge clk);
        checks++;
        if (o_busy !== 0 || s_ready !== 0) begin
            errors++;
            $display("FAIL zero_size_go got busy=%b s_ready=%b want 0 0", o_busy, s_ready);
        end
        @(posedge clk); #1;
        start_job(1, 1);
        @(negedge clk);
        checks++;
        if (o_overflow !== 0 || o_busy !== 1) begin
            errors++;
            $display("FAIL go_accept got ovf=%b busy=%b want 0 1", o_overflow, o_busy);
        end
        @(posedge clk); #1;
        send_beats(1 + NL, 0);
        fork
            mvm_respond(1, 3, 0);
            begin
                repeat (2) cycle();
                start_job(5, 3);
            end
        join
        wait_done(500);
        rows_expected(exp);
        check_results(exp);
        @(negedge clk);
        checks++;
        if (o_vec_num_words !== 1 || o_mat_num_rows_per_olane !== 1 || o_busy !== 0) begin
            errors++;
            $display("FAIL go_in_run got W=%0d R=%0d busy=%b want W=1 R=1 busy=0",
                     o_vec_num_words, o_mat_num_rows_per_olane, o_busy);
        end
        @(posedge clk); #1;
        ok = 1;
    endtask

    task automatic test_reset_mid();
        clear_logs();
        start_job(2, 1);
        send_beats(2 + 5, 0);
        s_valid = 1; s_data = {$urandom, $urandom};
        #2 rst = 0;
        @(negedge clk);
        checks++;
        if (o_busy !== 0 || s_ready !== 0 || o_mat_wen !== 0 || o_vec_wen !== 0 || r_valid !== 0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b s_ready=%b mwen=%b vwen=%b rv=%b want all 0",
                     o_busy, s_ready, o_mat_wen, o_vec_wen, r_valid);
        end
        @(posedge clk); #1;
        s_valid = 0;
        rst = 1;
        cycle();
        run_job(2, 1, 1, 2, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_stall();
        test_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
